// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared BCD definitions for the BCD counter family.
//   BCD_MAX / BCD_ZERO : largest and smallest legal BCD digit values
//   bcd_digit_t        : one packed BCD digit (4 bits)
//   bcd_clamp()        : maps an illegal digit (10..15) to 9, passes 0..9 through
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Loaded digits are the only way an illegal code could enter the counter,
  // so clamping here keeps the whole count valid BCD at all times.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    bcd_digit_t r;
    r = (d > BCD_MAX) ? BCD_MAX : d;
    return r;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_down_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_down_counter_if
// Control and status bundle of the BCD down counter.
//   load     : synchronous parallel load strobe
//   load_val : packed BCD value to load, digit [3:0] least significant
//   en       : count enable, one decrement per rising edge
//   q        : current count, packed BCD
//   zero     : q is all-zero (decoded straight from the count register)
//   tc       : one-cycle pulse, count reached zero by a decrement
//   borrow   : one-cycle pulse, count wrapped from zero to all-nine
//
// Handshake: there is no valid/ready pair. load and en are level qualifiers
// sampled on every rising clock edge; the counter never back-pressures, so the
// controlling side may change them on any cycle and the effect is visible on
// q/tc/borrow one clock later.
//
// Modports:
//   master : the controlling side (drives load/load_val/en, observes status)
//   slave  : the counter itself
// -----------------------------------------------------------------------------
interface bcd_down_counter_if #(
  parameter int DIGITS = 2
);

  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic [4*DIGITS-1:0]   q;
  logic                  zero;
  logic                  tc;
  logic                  borrow;

  modport master (
    output load,
    output load_val,
    output en,
    input  q,
    input  zero,
    input  tc,
    input  borrow
  );

  modport slave (
    input  load,
    input  load_val,
    input  en,
    output q,
    output zero,
    output tc,
    output borrow
  );

endinterface : bcd_down_counter_if

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
// One BCD digit of the down counter: a 4-bit register with parallel load and a
// borrow-in/borrow-out pair for chaining digits combinationally.
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset, clears the digit to 0
//   load       : load strobe, takes priority over borrow_in
//   load_digit : digit value to load (clamped to 9 if illegal)
//   borrow_in  : decrement request for this digit
//   borrow_out : borrow passed to the next more-significant digit
//   digit_q    : current digit value
//   is_zero    : digit_q == 0
// -----------------------------------------------------------------------------
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       borrow_in,
  output logic       borrow_out,
  output bcd_digit_t digit_q,
  output logic       is_zero
);

  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (borrow_in) begin
      // 0 rolls under to 9 and the borrow moves on; any other value just steps down.
      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign is_zero    = (digit_q == BCD_ZERO);
  assign borrow_out = borrow_in & is_zero;

endmodule : bcd_down_digit

// File: rtl/bcd_down_counter.sv
// -----------------------------------------------------------------------------
// bcd_down_counter
// Synchronous multi-digit BCD down counter with parallel load, terminal-count
// and wrap (borrow) pulses. All digits update on the same clock edge; the
// borrow chain between them is purely combinational.
//   DIGITS : number of BCD digits (1..8), count width 4*DIGITS
//   WRAP   : 1 = 0 wraps to all-nine, 0 = count holds at zero
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset (q=0, tc=0, borrow=0)
//   bus    : slave side of bcd_down_counter_if (load/load_val/en in,
//            q/zero/tc/borrow out)
// Priority: reset, load, en, hold.
// -----------------------------------------------------------------------------
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_down_counter_if.slave    bus
);

  logic [DIGITS:0]       borrow_chain;
  logic [DIGITS-1:0]     digit_zero;
  logic [4*DIGITS-1:0]   count;
  logic                  all_zero;
  logic                  upper_zero;
  logic                  one_left;
  logic                  dec_go;

  logic                  tc_d;
  logic                  tc_q;
  logic                  borrow_d;
  logic                  borrow_q;

  assign all_zero = &digit_zero;

  // A load overrides counting; without WRAP the decrement is suppressed at
  // zero so the chain never rolls the count under.
  assign dec_go          = bus.en & ~bus.load & (WRAP | ~all_zero);
  assign borrow_chain[0] = dec_go;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (bus.load),
      .load_digit (bus.load_val[4*i +: 4]),
      .borrow_in  (borrow_chain[i]),
      .borrow_out (borrow_chain[i+1]),
      .digit_q    (count[4*i +: 4]),
      .is_zero    (digit_zero[i])
    );
  end

  // The count is exactly one when digit 0 holds 1 and every higher digit is 0;
  // decrementing from there is the only way to reach zero by counting.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      upper_zero = upper_zero & digit_zero[i];
    end
  end

  assign one_left = upper_zero & (count[3:0] == 4'd1);

  always_comb begin
    tc_d     = dec_go & one_left;
    // A borrow leaving the most significant digit can only happen when the
    // whole count was zero and the decrement was allowed, i.e. a wrap.
    borrow_d = borrow_chain[DIGITS];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      tc_q     <= tc_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.q      = count;
  assign bus.zero   = all_zero;
  assign bus.tc     = tc_q;
  assign bus.borrow = borrow_q;

endmodule : bcd_down_counter
